// File: rtl/seq_alu_if.sv
// seq_alu_if: request/response bundle between the operand latches and the
// seq_alu datapath.
//   master : drives start/op/a/b, observes result and status
//   slave  : the ALU; consumes the request, drives result/busy/done/flags
interface seq_alu_if #(
  parameter int WIDTH = 32
);
  logic               start;
  logic [4:0]         op;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [2*WIDTH-1:0] result;
  logic               busy;
  logic               done;
  logic               zero;
  logic               div_by_zero;
  logic               illegal_op;

  modport master (
    output start, op, a, b,
    input  result, busy, done, zero, div_by_zero, illegal_op
  );

  modport slave (
    input  start, op, a, b,
    output result, busy, done, zero, div_by_zero, illegal_op
  );
endinterface

// File: rtl/seq_alu.sv
// seq_alu: clocked ALU with a 2*WIDTH HI/LO result register.
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   bus        : seq_alu_if.slave
//                start/op/a/b in; result, busy, done, zero,
//                div_by_zero, illegal_op out (all registered)
// Single-cycle ops finish at the start edge. Signed MUL/DIV share one
// iterative engine operating on magnitudes (WIDTH steps), followed by a
// sign-fix state, so done arrives WIDTH+2 edges after start.
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  seq_alu_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = SHW + 1;

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX} state_e;

  state_e             state_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] acc_q;      // MUL: {partial hi, multiplier}; DIV: {rem, quotient}
  logic [WIDTH-1:0]   mag_b_q;    // multiplicand / divisor magnitude
  logic [WIDTH-1:0]   a_raw_q;    // dividend as given, for divide-by-zero HI
  logic               is_div_q;
  logic               neg_a_q;
  logic               neg_b_q;
  logic               b_zero_q;
  logic [2*WIDTH-1:0] result_q;
  logic               busy_q;
  logic               done_q;
  logic               zero_q;
  logic               dbz_q;
  logic               ill_q;

  logic [WIDTH-1:0]   sc_lo_d;
  logic               sc_ill_d;
  logic               is_multi_d;
  logic [2*WIDTH-1:0] sc_res_d;
  logic [2*WIDTH-1:0] step_d;
  logic [2*WIDTH-1:0] fix_res_d;
  logic [WIDTH:0]     mul_sum_s;
  logic [WIDTH:0]     div_sh_s;
  logic [WIDTH:0]     div_diff_s;
  logic [SHW-1:0]     sh_s;
  logic [SHW-1:0]     sh_inv_s;

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
    return (~x) + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? negate(x) : x;
  endfunction

  assign sh_s     = bus.b[SHW-1:0];
  // Complementary rotate amount (WIDTH - sh) mod WIDTH; zero maps to zero.
  assign sh_inv_s = {SHW{1'b0}} - sh_s;

  // Single-cycle operation decode.
  always_comb begin
    sc_lo_d    = {WIDTH{1'b0}};
    sc_ill_d   = 1'b0;
    is_multi_d = 1'b0;
    case (bus.op)
      5'd0:  sc_lo_d = bus.a + bus.b;
      5'd1:  sc_lo_d = bus.a - bus.b;
      5'd2:  is_multi_d = 1'b1;
      5'd3:  is_multi_d = 1'b1;
      5'd4:  sc_lo_d = bus.a & bus.b;
      5'd5:  sc_lo_d = bus.a | bus.b;
      5'd6:  sc_lo_d = bus.a << sh_s;
      5'd7:  sc_lo_d = bus.a >> sh_s;
      5'd8:  sc_lo_d = (bus.a << sh_s) | (bus.a >> sh_inv_s);
      5'd9:  sc_lo_d = (bus.a >> sh_s) | (bus.a << sh_inv_s);
      5'd10: sc_lo_d = ~bus.b;
      5'd11: sc_lo_d = bus.a ^ bus.b;
      5'd12: sc_lo_d = ~(bus.a | bus.b);
      5'd13: sc_lo_d = ~(bus.a & bus.b);
      5'd14: sc_lo_d = $signed(bus.a) >>> sh_s;
      default: sc_ill_d = 1'b1;
    endcase
    sc_res_d = {{WIDTH{1'b0}}, sc_lo_d};
  end

  // One engine step: shift-add for MUL, restoring subtract for DIV.
  always_comb begin
    mul_sum_s  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                 (acc_q[0] ? {1'b0, mag_b_q} : {(WIDTH+1){1'b0}});
    div_sh_s   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff_s = div_sh_s - {1'b0, mag_b_q};
    if (is_div_q) begin
      // Borrow out of the trial subtract means the divisor did not fit.
      if (div_diff_s[WIDTH]) begin
        step_d = {div_sh_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      end else begin
        step_d = {div_diff_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end
    end else begin
      step_d = {mul_sum_s, acc_q[WIDTH-1:1]};
    end
  end

  // Sign correction of the magnitude result.
  always_comb begin
    fix_res_d = acc_q;
    if (!is_div_q) begin
      if (neg_a_q ^ neg_b_q) begin
        fix_res_d = (~acc_q) + {{(2*WIDTH-1){1'b0}}, 1'b1};
      end else begin
        fix_res_d = acc_q;
      end
    end else if (b_zero_q) begin
      fix_res_d = {a_raw_q, {WIDTH{1'b1}}};
    end else begin
      // Remainder follows the dividend's sign; quotient truncates to zero.
      fix_res_d[2*WIDTH-1:WIDTH] = neg_a_q ? negate(acc_q[2*WIDTH-1:WIDTH])
                                           : acc_q[2*WIDTH-1:WIDTH];
      fix_res_d[WIDTH-1:0]       = (neg_a_q ^ neg_b_q) ? negate(acc_q[WIDTH-1:0])
                                                       : acc_q[WIDTH-1:0];
    end
  end

  // Control FSM, engine state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= {CW{1'b0}};
      acc_q    <= {(2*WIDTH){1'b0}};
      mag_b_q  <= {WIDTH{1'b0}};
      a_raw_q  <= {WIDTH{1'b0}};
      is_div_q <= 1'b0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      b_zero_q <= 1'b0;
      result_q <= {(2*WIDTH){1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      zero_q   <= 1'b0;
      dbz_q    <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            if (is_multi_d) begin
              // MUL and DIV both start from {0, |a|} with |b| alongside.
              acc_q    <= {{WIDTH{1'b0}}, mag(bus.a)};
              mag_b_q  <= mag(bus.b);
              a_raw_q  <= bus.a;
              is_div_q <= bus.op[0];
              neg_a_q  <= bus.a[WIDTH-1];
              neg_b_q  <= bus.b[WIDTH-1];
              b_zero_q <= (bus.b == {WIDTH{1'b0}});
              cnt_q    <= {CW{1'b0}};
              busy_q   <= 1'b1;
              state_q  <= S_ITER;
            end else begin
              result_q <= sc_res_d;
              zero_q   <= (sc_res_d == {(2*WIDTH){1'b0}});
              ill_q    <= sc_ill_d;
              dbz_q    <= 1'b0;
              done_q   <= 1'b1;
            end
          end
        end
        S_ITER: begin
          if (cnt_q == CW'(WIDTH)) begin
            state_q <= S_FIX;
          end else begin
            acc_q <= step_d;
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_FIX: begin
          result_q <= fix_res_d;
          zero_q   <= (fix_res_d == {(2*WIDTH){1'b0}});
          dbz_q    <= is_div_q & b_zero_q;
          ill_q    <= 1'b0;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.result      = result_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.zero        = zero_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.illegal_op  = ill_q;
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: randomized + directed bench for seq_alu (WIDTH=32) with an
// arithmetic reference model and a per-cycle compare process.
module tb_seq_alu;
  localparam int W   = 32;
  localparam int LAT = W + 2;

  typedef struct {
    logic [63:0] res;
    logic        dbz;
    logic        ill;
    logic        multi;
  } model_t;

  typedef struct {
    model_t m;
    int     c0;
    int     due;
  } pend_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   free_at;
  int   n_checks;
  int   n_pass;
  bit   checking;
  pend_t pq[$];
  logic [63:0] last_res;
  logic        last_zero;
  logic        last_dbz;
  logic        last_ill;

  seq_alu_if #(.WIDTH(W)) bus ();

  seq_alu #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference: plain signed arithmetic on 64-bit values.
  function automatic model_t model(input logic [4:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
    model_t r;
    logic signed [63:0] sa, sb, q, rm, t;
    logic [31:0] lo;
    int s;
    sa = 64'(signed'(a));
    sb = 64'(signed'(b));
    s  = int'(b[4:0]);
    r.res = 64'd0; r.dbz = 1'b0; r.ill = 1'b0; r.multi = 1'b0;
    lo = 32'd0;
    case (op)
      5'd0:  lo = a + b;
      5'd1:  lo = a - b;
      5'd2:  begin r.multi = 1'b1; t = sa * sb; r.res = t; end
      5'd3:  begin
        r.multi = 1'b1;
        if (b == 32'd0) begin
          r.res = {a, 32'hFFFF_FFFF}; r.dbz = 1'b1;
        end else begin
          q = sa / sb; rm = sa % sb;
          r.res = {rm[31:0], q[31:0]};
        end
      end
      5'd4:  lo = a & b;
      5'd5:  lo = a | b;
      5'd6:  lo = a << s;
      5'd7:  lo = a >> s;
      5'd8:  begin lo = a; for (int i = 0; i < s; i++) lo = {lo[30:0], lo[31]}; end
      5'd9:  begin lo = a; for (int i = 0; i < s; i++) lo = {lo[0], lo[31:1]}; end
      5'd10: lo = ~b;
      5'd11: lo = a ^ b;
      5'd12: lo = ~(a | b);
      5'd13: lo = ~(a & b);
      5'd14: begin t = sa >>> s; lo = t[31:0]; end
      default: r.ill = 1'b1;
    endcase
    if (!r.multi) r.res = {32'd0, lo};
    return r;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  // Issue an op at the first negedge where the ALU will accept it.
  task automatic issue(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
    pend_t p;
    while (cyc < free_at) @(negedge clk);
    bus.start = 1'b1; bus.op = o; bus.a = x; bus.b = y;
    p.m   = model(o, x, y);
    p.c0  = cyc + 1;
    p.due = p.c0 + (p.m.multi ? LAT : 0);
    pq.push_back(p);
    free_at = p.due;
    @(negedge clk);
    bus.start = 1'b0;
    bus.op = 5'($urandom_range(0, 31)); bus.a = $urandom; bus.b = $urandom;
  endtask

  // Start pulse while busy: must be ignored, so nothing is queued.
  task automatic poke();
    if (cyc < free_at) begin
      bus.start = 1'b1;
      bus.op = 5'($urandom_range(0, 31)); bus.a = $urandom; bus.b = $urandom;
      @(negedge clk);
      bus.start = 1'b0;
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    logic  exp_done;
    logic  exp_busy;
    pend_t p;
    if (checking && rst_n) begin
      if (pq.size() > 0 && pq[0].due < cyc) begin
        chk("done_timeout", 64'(cyc), 64'(pq[0].due));
        void'(pq.pop_front());
      end
      exp_done = (pq.size() > 0) && (pq[0].due == cyc);
      exp_busy = (pq.size() > 0) && pq[0].m.multi && (cyc >= pq[0].c0) && (cyc < pq[0].due);
      chk("done", 64'(bus.done), 64'(exp_done));
      chk("busy", 64'(bus.busy), 64'(exp_busy));
      if (exp_done) begin
        p = pq.pop_front();
        last_res  = p.m.res;
        last_zero = (p.m.res == 64'd0);
        last_dbz  = p.m.dbz;
        last_ill  = p.m.ill;
      end
      chk("result", bus.result, last_res);
      chk("zero", 64'(bus.zero), 64'(last_zero));
      chk("div_by_zero", 64'(bus.div_by_zero), 64'(last_dbz));
      chk("illegal_op", 64'(bus.illegal_op), 64'(last_ill));
    end
  end

  initial begin
    model_t m;
    int c0;
    n_checks = 0; n_pass = 0; checking = 1'b0; free_at = 0;
    last_res = 64'd0; last_zero = 1'b0; last_dbz = 1'b0; last_ill = 1'b0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.op = 5'd0; bus.a = 32'd0; bus.b = 32'd0;

    // Model pinned to hand-computed values.
    m = model(5'd2, 32'hFFFF_FFFD, 32'd7);        chk("pin_mul_neg", m.res, 64'hFFFF_FFFF_FFFF_FFEB);
    m = model(5'd2, 32'h8000_0000, 32'h8000_0000); chk("pin_mul_min", m.res, 64'h4000_0000_0000_0000);
    m = model(5'd3, 32'hFFFF_FFF9, 32'd2);        chk("pin_div_neg", m.res, 64'hFFFF_FFFF_FFFF_FFFD);
    m = model(5'd3, 32'd5, 32'd0);                chk("pin_div_zero", m.res, 64'h0000_0005_FFFF_FFFF);
    chk("pin_div_zero_flag", 64'(m.dbz), 64'd1);
    m = model(5'd3, 32'h8000_0000, 32'hFFFF_FFFF); chk("pin_div_ovf", m.res, 64'h0000_0000_8000_0000);
    m = model(5'd8, 32'h8000_0001, 32'd4);        chk("pin_rol", m.res, 64'h18);
    m = model(5'd9, 32'h8000_0001, 32'h24);       chk("pin_ror", m.res, 64'h1800_0000);
    m = model(5'd14, 32'h8000_0001, 32'd4);       chk("pin_sra", m.res, 64'hF800_0000);
    m = model(5'd7, 32'h8000_0001, 32'h24);       chk("pin_shr", m.res, 64'h0800_0000);
    m = model(5'd20, 32'd1, 32'd1);               chk("pin_illegal", 64'(m.ill), 64'd1);
    m = model(5'd4, 32'hF0, 32'h3C);              chk("pin_and", m.res, 64'h30);

    // Reset state.
    #1;
    chk("rst_result", bus.result, 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_zero", 64'(bus.zero), 64'd0);
    chk("rst_dbz", 64'(bus.div_by_zero), 64'd0);
    chk("rst_ill", 64'(bus.illegal_op), 64'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    checking = 1'b1;
    @(negedge clk);
    free_at = cyc;

    // Reset during a MUL aborts it.
    issue(5'd2, 32'hFFFF_FFFD, 32'd7);
    c0 = pq[pq.size()-1].c0;
    wait_until(c0 + 9);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_result", bus.result, 64'd0);
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    chk("midrst_done", 64'(bus.done), 64'd0);
    chk("midrst_zero", 64'(bus.zero), 64'd0);
    pq.delete();
    last_res = 64'd0; last_zero = 1'b0; last_dbz = 1'b0; last_ill = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    free_at = cyc;
    issue(5'd0, 32'd2, 32'd3);

    // Multiplies, back to back.
    issue(5'd2, 32'hFFFF_FFFD, 32'd7);
    issue(5'd2, 32'h8000_0000, 32'h8000_0000);

    // DIV with ignored starts at relative cycles 5 and 20, ADD on done cycle.
    issue(5'd3, 32'hFFFF_FFF9, 32'd2);
    c0 = pq[pq.size()-1].c0;
    wait_until(c0 + 4);  poke();
    wait_until(c0 + 19); poke();
    issue(5'd0, 32'h1234, 32'h1);
    issue(5'd3, 32'd5, 32'd0);
    issue(5'd3, 32'h8000_0000, 32'hFFFF_FFFF);

    // Shift/rotate boundaries, with and without high bits in B.
    for (int k = 0; k < 2; k++) begin
      issue(5'd8, 32'h8000_0001, (k == 0) ? 32'd4 : 32'h24);
      issue(5'd9, 32'h8000_0001, (k == 0) ? 32'd4 : 32'h24);
      issue(5'd14, 32'h8000_0001, (k == 0) ? 32'd4 : 32'h24);
      issue(5'd7, 32'h8000_0001, (k == 0) ? 32'd4 : 32'h24);
    end

    // Illegal op, then a legal op clears the flag.
    issue(5'd20, 32'd7, 32'd9);
    issue(5'd4, 32'hF0, 32'h3C);

    // Randomized traffic.
    for (int n = 0; n < 250; n++) begin
      int r;
      logic [4:0] o;
      r = $urandom_range(0, 19);
      o = (r <= 14) ? 5'(r) : 5'($urandom_range(15, 31));
      issue(o, pick_operand(), pick_operand());
      if (cyc < free_at && $urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(0, 20)) @(negedge clk);
        poke();
      end
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    for (int i = 0; i < 200 && pq.size() > 0; i++) @(negedge clk);
    if (pq.size() != 0) chk("drain", 64'(pq.size()), 64'd0);
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
